// File: rtl/cmac_reset_pkg.sv
// Shared types and counter sizing for the CMAC reset sequencer.
package cmac_reset_pkg;

    localparam int RETRY_W = 4;
    localparam int MAX_CH  = 8;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_WAIT_ALIGN,
        ST_RUN
    } seq_state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cmac_rst_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module cmac_rst_timer
    import cmac_reset_pkg::*;
#(
    parameter int unsigned MAX_VAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int W = cnt_w(MAX_VAL);
    localparam logic [W-1:0] LOAD_VAL = W'(MAX_VAL);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= LOAD_VAL;
        else if (load)
            count <= LOAD_VAL;
        else if (dec && count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/cmac_reset_sequencer.sv
// Holds, staggers and releases per-channel CMAC resets, retrying channels
// that fail to align and flagging those that exhaust their retries.
module cmac_reset_sequencer
    import cmac_reset_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int HOLD_CYCLES    = 64,
    parameter int STAGGER_CYCLES = 16,
    parameter int ALIGN_TIMEOUT  = 100000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               init_clk,
    input  logic               src_areset,
    input  logic               sw_reset,
    input  logic [NUM_CH-1:0]  rx_aligned,
    output logic [NUM_CH-1:0]  init_reset,
    output logic [NUM_CH-1:0]  ready,
    output logic [NUM_CH-1:0]  fail,
    output logic               busy,
    output logic [RETRY_W-1:0] retries_used
);

    seq_state_e        state;
    logic [NUM_CH-1:0] tgt;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] low_tgt, low_pend, pend_rest;
    logic              all_aligned, can_retry;
    logic              hold_ld, hold_dec, hold_done;
    logic              stag_ld, stag_dec, stag_done;
    logic              to_ld, to_dec, to_done;

    function automatic logic [NUM_CH-1:0] low_bit(input logic [NUM_CH-1:0] m);
        return m & (~m + NUM_CH'(1));
    endfunction

    assign low_tgt     = low_bit(tgt);
    assign low_pend    = low_bit(pend);
    assign pend_rest   = pend & ~low_pend;
    assign all_aligned = &(rx_aligned | fail);
    assign can_retry   = retries_used < RETRY_W'(MAX_RETRIES);

    always_comb begin
        hold_ld  = 1'b0;
        hold_dec = 1'b0;
        stag_ld  = 1'b0;
        stag_dec = 1'b0;
        to_ld    = 1'b0;
        to_dec   = 1'b0;
        if (sw_reset) begin
            hold_ld = 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (hold_done) stag_ld  = 1'b1;
                    else           hold_dec = 1'b1;
                end
                ST_RELEASE: begin
                    if (pend == '0) begin
                        to_ld = 1'b1;
                    end else if (stag_done) begin
                        stag_ld = 1'b1;
                        to_ld   = (pend_rest == '0);
                    end else begin
                        stag_dec = 1'b1;
                    end
                end
                ST_WAIT_ALIGN: begin
                    if (!all_aligned) begin
                        if (!to_done)       to_dec  = 1'b1;
                        else if (can_retry) hold_ld = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    cmac_rst_timer #(.MAX_VAL(HOLD_CYCLES - 1)) u_hold (
        .clk(init_clk), .rst(src_areset), .load(hold_ld), .dec(hold_dec), .done(hold_done)
    );

    cmac_rst_timer #(.MAX_VAL(STAGGER_CYCLES - 1)) u_stagger (
        .clk(init_clk), .rst(src_areset), .load(stag_ld), .dec(stag_dec), .done(stag_done)
    );

    cmac_rst_timer #(.MAX_VAL(ALIGN_TIMEOUT)) u_timeout (
        .clk(init_clk), .rst(src_areset), .load(to_ld), .dec(to_dec), .done(to_done)
    );

    always_ff @(posedge init_clk or posedge src_areset) begin
        if (src_areset) begin
            state        <= ST_ASSERT;
            tgt          <= '1;
            pend         <= '0;
            init_reset   <= '1;
            ready        <= '0;
            fail         <= '0;
            busy         <= 1'b1;
            retries_used <= '0;
        end else if (sw_reset) begin
            state        <= ST_ASSERT;
            tgt          <= '1;
            pend         <= '0;
            init_reset   <= '1;
            ready        <= '0;
            fail         <= '0;
            busy         <= 1'b1;
            retries_used <= '0;
        end else begin
            ready <= '0;
            case (state)
                ST_ASSERT: begin
                    // First target channel drops on the same edge RELEASE is entered.
                    if (hold_done) begin
                        state      <= ST_RELEASE;
                        init_reset <= init_reset & ~low_tgt;
                        pend       <= tgt & ~low_tgt;
                    end
                end
                ST_RELEASE: begin
                    if (pend == '0) begin
                        state <= ST_WAIT_ALIGN;
                    end else if (stag_done) begin
                        init_reset <= init_reset & ~low_pend;
                        pend       <= pend_rest;
                        if (pend_rest == '0) state <= ST_WAIT_ALIGN;
                    end
                end
                ST_WAIT_ALIGN: begin
                    if (all_aligned) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else if (to_done) begin
                        // Aligned channels stay released; only laggards go back into reset.
                        init_reset <= init_reset | ~rx_aligned;
                        if (can_retry) begin
                            state        <= ST_ASSERT;
                            tgt          <= ~rx_aligned;
                            retries_used <= retries_used + RETRY_W'(1);
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                            fail  <= fail | ~rx_aligned;
                        end
                    end
                end
                ST_RUN: begin
                    ready <= rx_aligned & ~init_reset & ~fail;
                end
                default: state <= ST_ASSERT;
            endcase
        end
    end

endmodule

// File: tb/tb_cmac_reset_sequencer.sv
// Directed bench for cmac_reset_sequencer with NUM_CH=2, HOLD=8, STAGGER=4, TIMEOUT=100, MAX_RETRIES=2.
module tb_cmac_reset_sequencer;

    logic       init_clk = 1'b0;
    logic       src_areset;
    logic       sw_reset;
    logic [1:0] rx_aligned;
    logic [1:0] init_reset, ready, fail;
    logic       busy;
    logic [3:0] retries_used;

    int total = 0;
    int bad   = 0;

    cmac_reset_sequencer #(
        .NUM_CH(2), .HOLD_CYCLES(8), .STAGGER_CYCLES(4),
        .ALIGN_TIMEOUT(100), .MAX_RETRIES(2)
    ) dut (
        .init_clk(init_clk), .src_areset(src_areset), .sw_reset(sw_reset),
        .rx_aligned(rx_aligned), .init_reset(init_reset), .ready(ready),
        .fail(fail), .busy(busy), .retries_used(retries_used)
    );

    always #5 init_clk = ~init_clk;

    task automatic step(input int n);
        repeat (n) @(posedge init_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sw_pulse();
        sw_reset = 1'b1;
        step(1);
        sw_reset = 1'b0;
    endtask

    initial begin
        int n;
        src_areset = 1'b1;
        sw_reset   = 1'b0;
        rx_aligned = 2'b11;
        step(2);
        chk("rst_init_reset", 32'(init_reset), 'h3);
        chk("rst_ready", 32'(ready), 'h0);
        chk("rst_fail", 32'(fail), 'h0);
        chk("rst_busy", 32'(busy), 'h1);
        chk("rst_retries", 32'(retries_used), 'h0);

        // Power-on sequence
        src_areset = 1'b0;
        step(7);
        chk("po_hold_end", 32'(init_reset), 'h3);
        step(1);
        chk("po_ch0_drop", 32'(init_reset), 'h2);
        step(3);
        chk("po_ch1_still", 32'(init_reset), 'h2);
        step(1);
        chk("po_ch1_drop", 32'(init_reset), 'h0);
        chk("po_busy_wait", 32'(busy), 'h1);
        step(1);
        chk("po_busy0", 32'(busy), 'h0);
        step(1);
        chk("po_ready", 32'(ready), 'h3);

        // Alignment loss in RUN
        rx_aligned = 2'b10;
        step(1);
        chk("loss_ready", 32'(ready), 'h2);
        chk("loss_init_reset", 32'(init_reset), 'h0);
        chk("loss_busy", 32'(busy), 'h0);
        rx_aligned = 2'b11;
        step(1);
        chk("loss_recover", 32'(ready), 'h3);

        // Single retry
        rx_aligned = 2'b01;
        sw_pulse();
        chk("retry_sw_init", 32'(init_reset), 'h3);
        chk("retry_sw_busy", 32'(busy), 'h1);
        chk("retry_sw_ready", 32'(ready), 'h0);
        n = 0;
        while (retries_used != 4'd1 && n < 300) begin step(1); n++; end
        chk("retry_timeout1", 32'(retries_used), 'h1);
        chk("retry_mask", 32'(init_reset), 'h2);
        rx_aligned = 2'b11;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("retry_hold_ch1only", 32'(init_reset), 'h2);
        end
        step(1);
        chk("retry_release", 32'(init_reset), 'h0);
        step(2);
        chk("retry_busy0", 32'(busy), 'h0);
        step(1);
        chk("retry_ready", 32'(ready), 'h3);
        chk("retry_count", 32'(retries_used), 'h1);

        // Retry exhaustion
        rx_aligned = 2'b01;
        sw_pulse();
        chk("exh_sw_retries", 32'(retries_used), 'h0);
        n = 0;
        while (retries_used != 4'd1 && n < 300) begin step(1); n++; end
        chk("exh_timeout1", 32'(retries_used), 'h1);
        n = 0;
        while (retries_used != 4'd2 && n < 300) begin step(1); n++; end
        chk("exh_timeout2", 32'(retries_used), 'h2);
        n = 0;
        while (busy != 1'b0 && n < 300) begin step(1); n++; end
        chk("exh_busy0", 32'(busy), 'h0);
        chk("exh_fail", 32'(fail), 'h2);
        chk("exh_init_reset", 32'(init_reset), 'h2);
        chk("exh_retries", 32'(retries_used), 'h2);
        step(1);
        chk("exh_ready", 32'(ready), 'h1);

        // sw_reset mid-RELEASE, also clears fail from the previous test
        rx_aligned = 2'b11;
        sw_pulse();
        chk("mid_fail_clr", 32'(fail), 'h0);
        chk("mid_retries_clr", 32'(retries_used), 'h0);
        chk("mid_sw_ready", 32'(ready), 'h0);
        step(8);
        chk("mid_ch0_drop", 32'(init_reset), 'h2);
        step(2);
        sw_pulse();
        chk("mid_reassert", 32'(init_reset), 'h3);
        chk("mid_busy", 32'(busy), 'h1);
        step(7);
        chk("mid_full_hold", 32'(init_reset), 'h3);
        step(1);
        chk("mid_ch0_drop2", 32'(init_reset), 'h2);
        step(4);
        chk("mid_ch1_drop2", 32'(init_reset), 'h0);
        step(1);
        chk("mid_busy0", 32'(busy), 'h0);
        step(1);
        chk("mid_ready", 32'(ready), 'h3);

        // sw_reset coincident with the first timeout (edge 113 after the pulse)
        rx_aligned = 2'b01;
        sw_pulse();
        step(112);
        chk("coin_pre_retries", 32'(retries_used), 'h0);
        sw_pulse();
        chk("coin_retries", 32'(retries_used), 'h0);
        chk("coin_mask", 32'(init_reset), 'h3);
        chk("coin_busy", 32'(busy), 'h1);
        step(7);
        chk("coin_hold", 32'(init_reset), 'h3);
        step(1);
        chk("coin_ch0_drop", 32'(init_reset), 'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
